// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
//   Shared definitions for the load/store unit:
//     - lsu_state_e : FSM state encoding (IDLE / ACCESS / RESP)
//     - lsu_op_e    : operation encoding (NOP / LD / ST)
//     - CNT_W       : wait-counter width
//     - CNT_MAX     : largest wait count the counter can hold
//     - decode_op() : maps the is_ld/is_st request pair to an operation
// -----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_LD  = 2'd1,
        OP_ST  = 2'd2
    } lsu_op_e;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    // Both flags low or both high is treated as a no-operation.
    function automatic lsu_op_e decode_op(input logic is_ld, input logic is_st);
        lsu_op_e op;
        op = OP_NOP;
        if (is_ld && !is_st) begin
            op = OP_LD;
        end else if (is_st && !is_ld) begin
            op = OP_ST;
        end
        return op;
    endfunction

endpackage

// File: rtl/lsu_wait_timer.sv
// -----------------------------------------------------------------------------
// lsu_wait_timer
//   Loadable down-counter that times the ACCESS phase of the load/store unit.
//   Ports:
//     clk     in  rising-edge clock
//     rst     in  asynchronous active-high reset (counter -> 0)
//     load_i  in  load WAIT_CYCLES into the counter
//     dec_i   in  decrement (ignored when already zero)
//     zero_o  out counter is zero
// -----------------------------------------------------------------------------
module lsu_wait_timer
    import lsu_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(WAIT_CYCLES);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Initiator side of the data-memory load/store interface. Accepts one request
//   per valid/ready handshake, holds the memory strobes/address/data for
//   WAIT_CYCLES+1 ACCESS cycles, captures load data on the last ACCESS cycle and
//   returns a one-cycle response.
//
//   Optional feature (macro LSU_BOUNDS_CHK_EN): requests with
//   req_addr >= MEM_WORDS skip memory and respond with resp_err=1. Without the
//   macro resp_err is always 0 and addresses pass through unchanged.
//
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     req_valid / req_ready    request handshake (ready only in IDLE)
//     req_is_ld, req_is_st     operation select (both or neither = NOP)
//     req_addr, req_wdata      word address and store data
//     resp_valid               one-cycle response strobe
//     resp_rdata, resp_err     load data (held between responses), error flag
//     mem_isLd, mem_isSt       memory load / store enables
//     mem_address, mem_data_in memory address and write data
//     mem_data_out             memory read data (combinational)
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_WORDS   = 16,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_ld,
    input  logic              req_is_st,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_isLd,
    output logic              mem_isSt,
    output logic [DATA_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    if (WAIT_CYCLES > CNT_MAX) begin : g_bad_wait
        $error("load_store_unit: WAIT_CYCLES must be in 0..15");
    end
    if (MEM_WORDS < 1) begin : g_bad_words
        $error("load_store_unit: MEM_WORDS must be at least 1");
    end

    lsu_state_e        state_q, state_d;
    lsu_op_e           op_q,    op_d;
    logic [DATA_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q,   err_d;

    logic timer_load;
    logic timer_dec;
    logic cnt_zero;
    logic oob;
    logic in_access;

`ifdef LSU_BOUNDS_CHK_EN
    assign oob = (req_addr >= DATA_W'(MEM_WORDS));
`else
    assign oob = 1'b0;
`endif

    assign in_access = (state_q == ST_ACCESS);

    lsu_wait_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (timer_load),
        .dec_i  (timer_dec),
        .zero_o (cnt_zero)
    );

    // Next-state and register-update logic.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        timer_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d       = decode_op(req_is_ld, req_is_st);
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    err_d      = oob;
                    timer_load = 1'b1;
                    // NOP and out-of-range requests never touch memory.
                    if ((op_d == OP_NOP) || oob) begin
                        state_d = ST_RESP;
                        rdata_d = '0;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_zero) begin
                    state_d = ST_RESP;
                    rdata_d = (op_q == OP_LD) ? mem_data_out : '0;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign timer_dec = in_access && !cnt_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q && resp_valid;

    // Store strobe only on the final ACCESS cycle so memory sees one write.
    assign mem_isLd    = in_access && (op_q == OP_LD);
    assign mem_isSt    = in_access && (op_q == OP_ST) && cnt_zero;
    assign mem_address = in_access ? addr_q  : '0;
    assign mem_data_in = in_access ? wdata_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_ld;
    logic        req_is_st;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_isLd;
    logic        mem_isSt;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [16];

    always #5 clk = ~clk;

    load_store_unit #(
        .DATA_W      (32),
        .MEM_WORDS   (16),
        .WAIT_CYCLES (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_ld    (req_is_ld),
        .req_is_st    (req_is_st),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_isLd     (mem_isLd),
        .mem_isSt     (mem_isSt),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    // Memory model: combinational read, synchronous write.
    assign mem_data_out = (mem_address < 32'd16) ? mem[mem_address[3:0]] : 32'd0;

    always @(posedge clk) begin
        if (mem_isSt && (mem_address < 32'd16)) mem[mem_address[3:0]] <= mem_data_in;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one request, then count cycles (from the request cycle) until resp_valid.
    task automatic run_req(input logic ld, input logic st, input logic [31:0] addr,
                           input logic [31:0] wdata, output int lat, output int nld,
                           output int nst, output logic [31:0] rdata, output logic err,
                           output logic [31:0] seen_addr, output logic [31:0] seen_wdata);
        @(negedge clk);
        req_valid = 1'b1; req_is_ld = ld; req_is_st = st; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0; req_is_ld = 1'b0; req_is_st = 1'b0; req_addr = '0; req_wdata = '0;
        lat = 0; nld = 0; nst = 0; rdata = 'x; err = 1'bx; seen_addr = '0; seen_wdata = '0;
        for (int i = 1; i < 20; i++) begin
            nld += int'(mem_isLd);
            nst += int'(mem_isSt);
            if (mem_isLd || mem_isSt) seen_addr = mem_address;
            if (mem_isSt) seen_wdata = mem_data_in;
            if (resp_valid) begin
                lat = i; rdata = resp_rdata; err = resp_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_is_ld = 1'b0; req_is_st = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", resp_err); end
        checks++; if ({mem_isLd, mem_isSt} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b want 00", {mem_isLd, mem_isSt}); end
        checks++; if (mem_address !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem_address); end
        checks++; if (mem_data_in !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h want 0", mem_data_in); end
        rst = 1'b0;
    endtask

    task automatic test_load();
        int lat, nld, nst; logic [31:0] rd, sa, sw; logic er;
        run_req(1'b1, 1'b0, 32'd10, 32'd0, lat, nld, nst, rd, er, sa, sw);
        checks++; if (lat !== 3) begin errors++; $display("FAIL ld_latency: got %0d want 3", lat); end
        checks++; if (nld !== 2) begin errors++; $display("FAIL ld_isLd_cycles: got %0d want 2", nld); end
        checks++; if (nst !== 0) begin errors++; $display("FAIL ld_isSt_cycles: got %0d want 0", nst); end
        checks++; if (rd !== 32'd9) begin errors++; $display("FAIL ld_rdata: got %h want 9", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL ld_err: got %b want 0", er); end
        checks++; if (sa !== 32'd10) begin errors++; $display("FAIL ld_mem_addr: got %h want a", sa); end
    endtask

    task automatic test_store_load();
        int lat, nld, nst; logic [31:0] rd, sa, sw; logic er;
        run_req(1'b0, 1'b1, 32'd3, 32'hDEAD, lat, nld, nst, rd, er, sa, sw);
        checks++; if (lat !== 3) begin errors++; $display("FAIL st_latency: got %0d want 3", lat); end
        checks++; if (nst !== 1) begin errors++; $display("FAIL st_isSt_cycles: got %0d want 1", nst); end
        checks++; if (nld !== 0) begin errors++; $display("FAIL st_isLd_cycles: got %0d want 0", nld); end
        checks++; if (sw !== 32'hDEAD) begin errors++; $display("FAIL st_mem_data_in: got %h want dead", sw); end
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL st_rdata: got %h want 0", rd); end
        run_req(1'b1, 1'b0, 32'd3, 32'd0, lat, nld, nst, rd, er, sa, sw);
        checks++; if (rd !== 32'hDEAD) begin errors++; $display("FAIL st_then_ld_rdata: got %h want dead", rd); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL st_then_ld_latency: got %0d want 3", lat); end
    endtask

    task automatic test_back_to_back();
        int acc[4]; int nacc, nresp, rdy_low, bad_rd;
        nacc = 0; nresp = 0; rdy_low = 0; bad_rd = 0;
        acc[0] = -1; acc[1] = -1; acc[2] = -1; acc[3] = -1;
        @(negedge clk);
        req_valid = 1'b1; req_is_ld = 1'b1; req_is_st = 1'b0; req_addr = 32'd15; req_wdata = '0;
        for (int c = 0; c < 10; c++) begin
            if (req_ready) begin
                if (nacc < 4) acc[nacc] = c;
                nacc++;
            end else begin
                rdy_low++;
            end
            if (resp_valid) begin
                nresp++;
                if (resp_rdata !== 32'd2) bad_rd++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0; req_is_ld = 1'b0; req_addr = '0;
        repeat (4) @(negedge clk);
        checks++; if (nresp !== 2) begin errors++; $display("FAIL b2b_responses: got %0d want 2", nresp); end
        checks++; if (bad_rd !== 0) begin errors++; $display("FAIL b2b_rdata: %0d responses not equal to 2", bad_rd); end
        checks++; if (rdy_low !== 7) begin errors++; $display("FAIL b2b_ready_low: got %0d want 7", rdy_low); end
        checks++; if (acc[0] !== 0 || acc[1] !== 4 || acc[2] !== 8) begin
            errors++; $display("FAIL b2b_accept_cycles: got %0d,%0d,%0d want 0,4,8", acc[0], acc[1], acc[2]);
        end
    endtask

    task automatic test_reset_mid_store();
        int nresp, nst, lat, nld, nst2; logic [31:0] rd, sa, sw; logic er;
        nresp = 0; nst = 0;
        @(negedge clk);
        req_valid = 1'b1; req_is_ld = 1'b0; req_is_st = 1'b1; req_addr = 32'd7; req_wdata = 32'd1;
        @(negedge clk);
        req_valid = 1'b0; req_is_st = 1'b0; req_addr = '0; req_wdata = '0;
        checks++; if (mem_address !== 32'd7) begin errors++; $display("FAIL rst_mid_access_addr: got %h want 7", mem_address); end
        rst = 1'b1;
        #1;
        checks++; if (mem_isSt !== 1'b0 || mem_address !== 32'd0) begin
            errors++; $display("FAIL rst_mid_clear: isSt=%b addr=%h want 0/0", mem_isSt, mem_address);
        end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", req_ready); end
        #2 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            nresp += int'(resp_valid);
            nst += int'(mem_isSt);
        end
        checks++; if (nresp !== 0) begin errors++; $display("FAIL rst_mid_no_resp: got %0d want 0", nresp); end
        checks++; if (nst !== 0) begin errors++; $display("FAIL rst_mid_no_store: got %0d want 0", nst); end
        run_req(1'b1, 1'b0, 32'd7, 32'd0, lat, nld, nst2, rd, er, sa, sw);
        checks++; if (rd !== 32'd5) begin errors++; $display("FAIL rst_mid_ld7: got %h want 5", rd); end
    endtask

    task automatic test_nop();
        int lat, nld, nst; logic [31:0] rd, sa, sw; logic er;
        // Previous response left 5 in resp_rdata; NOP must clear it.
        run_req(1'b1, 1'b1, 32'd0, 32'h1234, lat, nld, nst, rd, er, sa, sw);
        checks++; if (lat !== 1) begin errors++; $display("FAIL nop_latency: got %0d want 1", lat); end
        checks++; if (nld + nst !== 0) begin errors++; $display("FAIL nop_strobes: got %0d want 0", nld + nst); end
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL nop_rdata: got %h want 0", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL nop_err: got %b want 0", er); end
        run_req(1'b0, 1'b0, 32'd0, 32'd0, lat, nld, nst, rd, er, sa, sw);
        checks++; if (lat !== 1 || nld + nst !== 0) begin
            errors++; $display("FAIL nop_zero_flags: lat=%0d strobes=%0d want 1/0", lat, nld + nst);
        end
    endtask

    task automatic test_bounds();
        int lat, nld, nst; logic [31:0] rd, sa, sw; logic er;
        // Seed resp_rdata with a non-zero value first.
        run_req(1'b1, 1'b0, 32'd10, 32'd0, lat, nld, nst, rd, er, sa, sw);
        run_req(1'b1, 1'b0, 32'd16, 32'd0, lat, nld, nst, rd, er, sa, sw);
`ifdef LSU_BOUNDS_CHK_EN
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL oob_err: got %b want 1", er); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL oob_latency: got %0d want 1", lat); end
        checks++; if (nld + nst !== 0) begin errors++; $display("FAIL oob_strobes: got %0d want 0", nld + nst); end
`else
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL oob_err: got %b want 0", er); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL oob_latency: got %0d want 3", lat); end
        checks++; if (nld !== 2 || sa !== 32'd16) begin
            errors++; $display("FAIL oob_passthru: isLd=%0d addr=%h want 2/10", nld, sa);
        end
`endif
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL oob_rdata: got %h want 0", rd); end
        @(negedge clk);
        checks++; if (resp_err !== 1'b0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL oob_after: err=%b valid=%b want 0/0", resp_err, resp_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'd5;
        mem[10] = 32'd9;
        mem[15] = 32'd2;
        test_reset();
        test_load();
        test_store_load();
        test_back_to_back();
        test_reset_mid_store();
        test_nop();
        test_bounds();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
